// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states,
// writeback/next-PC select codes, latched class bundle, one-hot helper.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    typedef struct packed {
        logic alureg;
        logic aluimm;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic load;
        logic store;
    } cls_t;

    function automatic logic is_onehot10(input logic [9:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n == 1;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: W-bit, increments on en, wraps.
// Ports: clk, rst_n (async clear), en, count.
module retire_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  count <= '0;
        else if (en) count <= count + 1'b1;
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Fetch/decode/exec/mem/wb timing FSM for the simple CPU.
// Ports: class flags + ready handshakes in; memory, PC, IR, RF strobes out.
import multicycle_sequencer_pkg::*;

module multicycle_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            ALUreg,
    input  logic            ALUimm,
    input  logic            Branch,
    input  logic            JAL,
    input  logic            JALR,
    input  logic            LUI,
    input  logic            AUIPC,
    input  logic            Load,
    input  logic            Store,
    input  logic            SYSTEM,
    input  logic            branch_taken,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            ir_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            rf_we,
    output logic [1:0]      wb_sel,
    output logic            pc_we,
    output logic [1:0]      pc_sel,
    output logic            halted,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instret
);

    state_t     st;
    cls_t       cls;
    logic [9:0] flags;

    assign flags = {ALUreg, ALUimm, Branch, JAL, JALR,
                    LUI, AUIPC, Load, Store, SYSTEM};
    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= S_IDLE;
            cls    <= '0;
            halted <= 1'b0;
        end else begin
            case (st)
                S_IDLE:  if (run) st <= S_FETCH;
                S_FETCH: if (imem_ready) st <= S_DECODE;
                S_DECODE: begin
                    cls <= cls_t'(flags[9:1]);
                    if (!is_onehot10(flags) || SYSTEM) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cls.branch)
                        st <= S_FETCH;
                    else if (cls.load || cls.store)
                        st <= S_MEM;
                    else if (cls.alureg || cls.aluimm || cls.lui ||
                             cls.auipc || cls.jal || cls.jalr)
                        st <= S_WB;
                    else begin
                        // unreachable class; stop rather than run on
                        st     <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_MEM:   if (dmem_ready) st <= cls.load ? S_WB : S_FETCH;
                S_WB:    st <= S_FETCH;
                S_HALT:  st <= S_HALT;
                default: st <= S_IDLE;
            endcase
        end
    end

    // Moore decode; only ir_we, store pc_we and branch pc_sel
    // follow their ready/compare input in the same cycle.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;
        case (st)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                if (cls.branch) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_TARGET : PC_PLUS4;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.store;
                pc_we    = cls.store & dmem_ready;
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                unique case (1'b1)
                    cls.load: wb_sel = WB_MEM;
                    cls.jal: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_TARGET;
                    end
                    cls.jalr: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_JALR;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    retire_counter #(.W(XLEN)) u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_we),
        .count (instret)
    );

endmodule
